// File: rtl/stroke_phase_detector_if.sv
// Signal bundle between the flywheel sensor path and the drive/recovery counter.
// The master modport is the detector side; slave is the sensor/consumer side.
interface stroke_phase_detector_if;
  logic        sensor_in;
  logic        start_drive;
  logic        start_recovery;
  logic        phase;
  logic [31:0] interval;
  logic        interval_valid;
  logic        stalled;

  modport master (
    input  sensor_in,
    output start_drive,
    output start_recovery,
    output phase,
    output interval,
    output interval_valid,
    output stalled
  );

  modport slave (
    output sensor_in,
    input  start_drive,
    input  start_recovery,
    input  phase,
    input  interval,
    input  interval_valid,
    input  stalled
  );
endinterface

// File: rtl/stroke_phase_detector.sv
// Classifies flywheel tick-interval trends into drive/recovery phase changes and
// emits mutually exclusive one-cycle start pulses for the downstream counter.
module stroke_phase_detector #(
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned HYST     = 4,
  parameter int unsigned CONFIRM  = 2,
  parameter int unsigned TIMEOUT  = 50000000
) (
  input logic                    clk,
  input logic                    reset,
  stroke_phase_detector_if.master bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StRecovery} state_e;

  localparam int unsigned DebW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned ConfW = $clog2(CONFIRM + 1);
  localparam logic [DebW-1:0]  DebLast    = DebW'(DEBOUNCE - 1);
  localparam logic [ConfW-1:0] ConfMax    = ConfW'(CONFIRM);
  localparam logic [31:0]      TimeoutVal = 32'(TIMEOUT);
  localparam logic [32:0]      Hyst33     = 33'(HYST);

  state_e state_q, state_d;

  logic            sync1_q, sync2_q;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            filt_q, filt_d;
  logic            tick;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] interval_q, interval_d;
  logic        valid_q;
  logic [31:0] prev_q, prev_d;
  logic        have_prev_q, have_prev_d;
  logic        timeout_hit;

  logic [ConfW-1:0] conf_q, conf_d, conf_n;
  logic             dir_q, dir_d;  // pending direction: 1 = ACC, 0 = DEC
  logic             acc, dec, acc_eff, dec_eff;
  logic             sd_d, sr_d, sd_q, sr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.sensor_in;
      sync2_q <= sync1_q;
    end
  end

  // Filtered level flips only after DEBOUNCE consecutive differing samples.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    tick      = 1'b0;
    if (sync2_q == filt_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebLast) begin
      filt_d    = sync2_q;
      deb_cnt_d = '0;
      tick      = sync2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DebW'(1);
    end
  end

  always_comb begin
    cnt_d       = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    interval_d  = interval_q;
    if (tick) begin
      cnt_d      = '0;
      interval_d = cnt_q;
    end
    timeout_hit = (cnt_q == TimeoutVal) && !tick;
  end

  assign acc     = valid_q && have_prev_q &&
                   (({1'b0, interval_q} + Hyst33) < {1'b0, prev_q});
  assign dec     = valid_q && have_prev_q &&
                   ({1'b0, interval_q} > ({1'b0, prev_q} + Hyst33));
  assign acc_eff = acc;
  assign dec_eff = dec && (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    conf_d      = conf_q;
    conf_n      = conf_q;
    dir_d       = dir_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    sd_d        = 1'b0;
    sr_d        = 1'b0;
    if (timeout_hit) begin
      state_d     = StIdle;
      have_prev_d = 1'b0;
      conf_d      = '0;
    end else if (valid_q) begin
      prev_d      = interval_q;
      have_prev_d = 1'b1;
      if (acc_eff || dec_eff) begin
        if (dir_q == acc_eff) begin
          conf_n = (conf_q == ConfMax) ? conf_q : conf_q + ConfW'(1);
        end else begin
          conf_n = ConfW'(1);
        end
        dir_d  = acc_eff;
        conf_d = conf_n;
        if (conf_n == ConfMax) begin
          if (acc_eff && (state_q != StDrive)) begin
            state_d = StDrive;
            sd_d    = 1'b1;
            conf_d  = '0;
          end else if (dec_eff && (state_q == StDrive)) begin
            state_d = StRecovery;
            sr_d    = 1'b1;
            conf_d  = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt_q   <= '0;
      filt_q      <= 1'b0;
      cnt_q       <= '0;
      interval_q  <= '0;
      valid_q     <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      conf_q      <= '0;
      dir_q       <= 1'b0;
      state_q     <= StIdle;
      sd_q        <= 1'b0;
      sr_q        <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      interval_q  <= interval_d;
      valid_q     <= tick;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      conf_q      <= conf_d;
      dir_q       <= dir_d;
      state_q     <= state_d;
      sd_q        <= sd_d;
      sr_q        <= sr_d;
    end
  end

  assign bus.start_drive    = sd_q;
  assign bus.start_recovery = sr_q;
  assign bus.phase          = (state_q == StDrive);
  assign bus.stalled        = (state_q == StIdle);
  assign bus.interval       = interval_q;
  assign bus.interval_valid = valid_q;

endmodule

// File: tb/tb_stroke_phase_detector.sv
// Directed bench: table of tick intervals with expected pulses/phase, plus
// hand-written glitch, stall and reset sequences.
module tb_stroke_phase_detector;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stroke_phase_detector_if bus ();

  stroke_phase_detector #(
    .DEBOUNCE (4),
    .HYST     (2),
    .CONFIRM  (2),
    .TIMEOUT  (1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned v;
    bit          sd;
    bit          sr;
    bit          ph;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned iv_cnt = 0, sd_cnt = 0, sr_cnt = 0, both_cnt = 0;
  int unsigned iv_cyc = 0, sd_cyc = 0, sr_cyc = 0;
  int unsigned rise_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock step; outputs sampled 1ns after the rising edge.
  task automatic cyc1();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.interval_valid) begin iv_cnt++; iv_cyc = cyc; end
    if (bus.start_drive) begin sd_cnt++; sd_cyc = cyc; end
    if (bus.start_recovery) begin sr_cnt++; sr_cyc = cyc; end
    if (bus.start_drive && bus.start_recovery) both_cnt++;
  endtask

  // Rising edges of consecutive calls are v+1 cycles apart -> interval v.
  task automatic apply(input int unsigned v);
    bus.sensor_in = 1'b0;
    repeat (v - 9) cyc1();
    bus.sensor_in = 1'b1;
    rise_cyc = cyc;
    repeat (10) cyc1();
  endtask

  task automatic apply_check(input string name, input int unsigned v, input bit chk_val,
                             input logic [31:0] exp_val, input bit exp_sd,
                             input bit exp_sr, input bit exp_ph);
    int unsigned iv0, sd0, sr0;
    iv0 = iv_cnt; sd0 = sd_cnt; sr0 = sr_cnt;
    apply(v);
    chk({name, "_ivcount"}, iv_cnt - iv0, 1);
    chk({name, "_ivtime"}, iv_cyc, rise_cyc + 6);
    if (chk_val) chk({name, "_interval"}, bus.interval, exp_val);
    chk({name, "_sd"}, sd_cnt - sd0, 32'(exp_sd));
    chk({name, "_sr"}, sr_cnt - sr0, 32'(exp_sr));
    chk({name, "_phase"}, 32'(bus.phase), 32'(exp_ph));
    if (exp_sd) chk({name, "_sdtime"}, sd_cyc, rise_cyc + 7);
    if (exp_sr) chk({name, "_srtime"}, sr_cyc, rise_cyc + 7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int unsigned sd0, sr0, iv0, target, old_rise;
    logic [31:0] last_iv;

    tbl[0]  = '{200, 1'b0, 1'b0, 1'b0};  // DEC ignored in IDLE
    tbl[1]  = '{180, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{160, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{170, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{190, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{100, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{101, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{99,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{100, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{90,  1'b1, 1'b0, 1'b1};  // neutrals held the pending ACC
    tbl[10] = '{92,  1'b0, 1'b0, 1'b1};  // cur == prev+HYST is neutral
    tbl[11] = '{95,  1'b0, 1'b0, 1'b1};
    tbl[12] = '{98,  1'b0, 1'b1, 1'b0};
    tbl[13] = '{96,  1'b0, 1'b0, 1'b0};  // cur+HYST == prev is neutral
    tbl[14] = '{93,  1'b0, 1'b0, 1'b0};
    tbl[15] = '{90,  1'b1, 1'b0, 1'b1};

    bus.sensor_in = 1'b0;
    repeat (3) cyc1();
    chk("rst_stalled", 32'(bus.stalled), 1);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_sd", 32'(bus.start_drive), 0);
    chk("rst_sr", 32'(bus.start_recovery), 0);
    chk("rst_interval", bus.interval, 0);
    chk("rst_valid", 32'(bus.interval_valid), 0);
    reset = 1'b1;

    apply_check("first", 30, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      apply_check($sformatf("row%0d", i), tbl[i].v, 1'b1, tbl[i].v,
                  tbl[i].sd, tbl[i].sr, tbl[i].ph);
    end

    // 2-cycle glitch between ticks
    iv0 = iv_cnt;
    last_iv = 32'd90;
    bus.sensor_in = 1'b0;
    repeat (20) cyc1();
    bus.sensor_in = 1'b1;
    repeat (2) cyc1();
    bus.sensor_in = 1'b0;
    repeat (20) cyc1();
    chk("glitch_ivcount", iv_cnt - iv0, 0);
    chk("glitch_interval", bus.interval, last_iv);
    chk("glitch_phase", 32'(bus.phase), 1);

    // Stall: counter hits TIMEOUT 1006 samples after the last rise
    sd0 = sd_cnt; sr0 = sr_cnt;
    target = rise_cyc + 1006;
    for (int i = 0; i < 2000 && cyc < target; i++) cyc1();
    chk("prestall_stalled", 32'(bus.stalled), 0);
    chk("prestall_phase", 32'(bus.phase), 1);
    cyc1();
    chk("stall_stalled", 32'(bus.stalled), 1);
    chk("stall_phase", 32'(bus.phase), 0);
    repeat (5) cyc1();
    chk("stall_sd", sd_cnt - sd0, 0);
    chk("stall_sr", sr_cnt - sr0, 0);

    old_rise = rise_cyc;
    apply_check("poststall0", 300, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("poststall0_value", bus.interval, rise_cyc - old_rise - 1);
    chk("poststall0_stalled", 32'(bus.stalled), 1);
    apply_check("poststall1", 300, 1'b1, 32'd300, 1'b0, 1'b0, 1'b0);
    apply_check("poststall2", 280, 1'b1, 32'd280, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-DRIVE
    reset = 1'b0;
    bus.sensor_in = 1'b0;
    #1;
    chk("midrst_phase", 32'(bus.phase), 0);
    chk("midrst_stalled", 32'(bus.stalled), 1);
    chk("midrst_sd", 32'(bus.start_drive), 0);
    chk("midrst_sr", 32'(bus.start_recovery), 0);
    chk("midrst_interval", bus.interval, 0);
    repeat (3) cyc1();
    reset = 1'b1;
    // First tick lands 36 cycles after release: counter 36
    apply_check("rst_t0", 40, 1'b1, 32'd36, 1'b0, 1'b0, 1'b0);
    apply_check("rst_t1", 30, 1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
    apply_check("rst_t2", 25, 1'b1, 32'd25, 1'b1, 1'b0, 1'b1);

    chk("pulse_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
